aead_serial_frontend: RTL and testbench

- Parametrised serial front end for the Ascon AEAD datapath. Supports both encryption and decryption.
- Accepts key, nonce, associated data, text and (when decrypting) the expected tag over a W-bit valid/ready stream. It launches an external AEAD core and streams results back over a W-bit valid/ready stream.
- Decryption releases plaintext only after the tag verifies.
- Sits between the board-level serial pins and the Encryption/Decryption cores.

---
 rtl/aead_serial_frontend.sv | 171 +++++++++++++++++
 tb/tb_aead_serial_frontend.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aead_serial_frontend.sv
// Serial front end for the Ascon AEAD core: loads key/nonce/AD/text(/tag) over a W-bit stream,
// launches the core, checks the tag on decrypt and streams the result back out.
module aead_serial_frontend #(
    parameter int unsigned K = 128,
    parameter int unsigned L = 40,
    parameter int unsigned Y = 40,
    parameter int unsigned W = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           mode,
    output logic           busy,
    input  logic           in_valid,
    input  logic [W-1:0]   in_data,
    output logic           in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    input  logic           out_ready,
    output logic           out_last,
    output logic           auth_valid,
    output logic           auth_ok,
    output logic [K-1:0]   core_key,
    output logic [127:0]   core_nonce,
    output logic [L-1:0]   core_ad,
    output logic [Y-1:0]   core_text,
    output logic           core_mode,
    output logic           core_start,
    input  logic           core_done,
    input  logic [Y-1:0]   core_text_out,
    input  logic [127:0]   core_tag
);
    localparam int unsigned T       = 128;
    localparam int unsigned NInEnc  = (K + T + L + Y) / W;
    localparam int unsigned NInDec  = NInEnc + T / W;
    localparam int unsigned NOutEnc = (Y + T) / W;
    localparam int unsigned NOutDec = Y / W;
    localparam int unsigned NMax    = (NInDec > NOutEnc) ? NInDec : NOutEnc;
    localparam int unsigned CW      = $clog2(NMax + 1);

    // Beat index at which each input field ends
    localparam logic [CW-1:0] EndKey   = CW'(K / W);
    localparam logic [CW-1:0] EndNonce = CW'((K + T) / W);
    localparam logic [CW-1:0] EndAd    = CW'((K + T + L) / W);
    localparam logic [CW-1:0] EndText  = CW'(NInEnc);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StRun  = 2'd2;
    localparam logic [1:0] StOut  = 2'd3;

    if ((K % W) != 0 || (T % W) != 0 || (L % W) != 0 || (Y % W) != 0) begin : g_width_check
        $error("aead_serial_frontend: W must divide K, 128, L and Y");
    end

    logic [1:0]     state_q;
    logic [CW-1:0]  cnt_q;
    logic           mode_q;
    logic           start_q;
    logic           auth_valid_q;
    logic           auth_ok_q;
    logic [K-1:0]   key_q;
    logic [T-1:0]   nonce_q;
    logic [T-1:0]   tag_q;
    logic [L-1:0]   ad_q;
    logic [Y-1:0]   text_q;
    logic [Y+T-1:0] out_q;

    logic           in_fire;
    logic           out_fire;
    logic           tag_match;
    logic [CW-1:0]  in_last_idx;
    logic [CW-1:0]  out_last_idx;

    assign in_fire      = (state_q == StLoad) && in_valid;
    assign out_fire     = (state_q == StOut) && out_ready;
    assign tag_match    = (core_tag == tag_q);
    assign in_last_idx  = mode_q ? CW'(NInDec - 1) : CW'(NInEnc - 1);
    assign out_last_idx = mode_q ? CW'(NOutDec - 1) : CW'(NOutEnc - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            start_q      <= 1'b0;
            auth_valid_q <= 1'b0;
            auth_ok_q    <= 1'b0;
            key_q        <= '0;
            nonce_q      <= '0;
            tag_q        <= '0;
            ad_q         <= '0;
            text_q       <= '0;
            out_q        <= '0;
        end else begin
            start_q      <= 1'b0;
            auth_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        mode_q  <= mode;
                        cnt_q   <= '0;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (in_fire) begin
                        if (cnt_q < EndKey)        key_q   <= (key_q << W) | K'(in_data);
                        else if (cnt_q < EndNonce) nonce_q <= (nonce_q << W) | T'(in_data);
                        else if (cnt_q < EndAd)    ad_q    <= (ad_q << W) | L'(in_data);
                        else if (cnt_q < EndText)  text_q  <= (text_q << W) | Y'(in_data);
                        else                       tag_q   <= (tag_q << W) | T'(in_data);
                        if (cnt_q == in_last_idx) begin
                            cnt_q   <= '0;
                            start_q <= 1'b1;
                            state_q <= StRun;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                StRun: begin
                    if (core_done) begin
                        if (!mode_q) begin
                            out_q   <= {core_text_out, core_tag};
                            state_q <= StOut;
                        end else begin
                            auth_valid_q <= 1'b1;
                            auth_ok_q    <= tag_match;
                            // A failed tag never lets plaintext reach the output register
                            if (tag_match) begin
                                out_q   <= {core_text_out, {T{1'b0}}};
                                state_q <= StOut;
                            end else begin
                                out_q   <= '0;
                                state_q <= StIdle;
                            end
                        end
                    end
                end
                StOut: begin
                    if (out_fire) begin
                        out_q <= out_q << W;
                        if (cnt_q == out_last_idx) begin
                            cnt_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy       = (state_q != StIdle);
    assign in_ready   = (state_q == StLoad);
    assign out_valid  = (state_q == StOut);
    assign out_data   = out_q[Y+T-1 -: W];
    assign out_last   = (state_q == StOut) && (cnt_q == out_last_idx);
    assign auth_valid = auth_valid_q;
    assign auth_ok    = auth_valid_q & auth_ok_q;
    assign core_key   = key_q;
    assign core_nonce = nonce_q;
    assign core_ad    = ad_q;
    assign core_text  = text_q;
    assign core_mode  = mode_q;
    assign core_start = start_q;

endmodule

// File: tb/tb_aead_serial_frontend.sv
// Bench for aead_serial_frontend: a W=1 and a W=8 instance share a toy core model; random
// field values are checked against a bit-stream reference model.
module tb_aead_serial_frontend;
    localparam logic [127:0] TAG  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [39:0]  MASK = 40'hA5A5A5A5A5;

    logic clk = 1'b0;
    logic rst, start, mode, in_valid, out_ready, sel;
    logic [7:0] in_data;
    int errors = 0;
    int checks = 0;
    int core_dly = 1;

    logic b1, b8, ir1, ir8, ov1, ov8, ol1, ol8, av1, av8, ao1, ao8, cm1, cm8, cs1, cs8;
    logic [0:0] od1;
    logic [7:0] od8;
    logic [127:0] ck1, ck8, cn1, cn8;
    logic [39:0] ca1, ca8, ct1, ct8;

    logic busy, ir, ov, ol, av, ao, cm, cs, c_done;
    logic [7:0] od;
    logic [127:0] ck, cn, c_tag;
    logic [39:0] ca, ct, c_text_out;

    logic [127:0] key, nonce;
    logic [39:0] ad, text;

    always #5 clk = ~clk;

    assign busy = sel ? b8 : b1;
    assign ir   = sel ? ir8 : ir1;
    assign ov   = sel ? ov8 : ov1;
    assign ol   = sel ? ol8 : ol1;
    assign av   = sel ? av8 : av1;
    assign ao   = sel ? ao8 : ao1;
    assign cm   = sel ? cm8 : cm1;
    assign cs   = sel ? cs8 : cs1;
    assign od   = sel ? od8 : {7'b0, od1};
    assign ck   = sel ? ck8 : ck1;
    assign cn   = sel ? cn8 : cn1;
    assign ca   = sel ? ca8 : ca1;
    assign ct   = sel ? ct8 : ct1;

    // Toy core: fixed tag, text XOR mask, done after core_dly cycles (0 = same cycle)
    logic pend;
    int pend_cnt;
    always @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
        end else if (cs && core_dly != 0) begin
            pend     <= 1'b1;
            pend_cnt <= core_dly - 1;
        end else if (pend) begin
            if (pend_cnt == 0) pend <= 1'b0;
            else pend_cnt <= pend_cnt - 1;
        end
    end
    assign c_done     = (cs && core_dly == 0) || (pend && pend_cnt == 0);
    assign c_text_out = ct ^ MASK;
    assign c_tag      = TAG;

    aead_serial_frontend #(.K(128), .L(40), .Y(40), .W(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start & ~sel), .mode(mode), .busy(b1),
        .in_valid(in_valid & ~sel), .in_data(in_data[0:0]), .in_ready(ir1),
        .out_valid(ov1), .out_data(od1), .out_ready(out_ready), .out_last(ol1),
        .auth_valid(av1), .auth_ok(ao1), .core_key(ck1), .core_nonce(cn1), .core_ad(ca1),
        .core_text(ct1), .core_mode(cm1), .core_start(cs1), .core_done(c_done),
        .core_text_out(c_text_out), .core_tag(c_tag)
    );

    aead_serial_frontend #(.K(128), .L(40), .Y(40), .W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start & sel), .mode(mode), .busy(b8),
        .in_valid(in_valid & sel), .in_data(in_data), .in_ready(ir8),
        .out_valid(ov8), .out_data(od8), .out_ready(out_ready), .out_last(ol8),
        .auth_valid(av8), .auth_ok(ao8), .core_key(ck8), .core_nonce(cn8), .core_ad(ca8),
        .core_text(ct8), .core_mode(cm8), .core_start(cs8), .core_done(c_done),
        .core_text_out(c_text_out), .core_tag(c_tag)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input bit w8, input bit dec, input bit flip, input bit gaps,
                          input bit stall, input bit run_start, input bit last_start,
                          input int dly);
        int w, n_in, n_out, i, cyc, nb, done_cyc, first_ov, auth_cyc, starts, stall_left;
        logic [7:0] d, e, held;
        logic [463:0] ib;
        logic [167:0] eb;
        logic [127:0] etag;
        bit acc, fin, did_stall, aok_seen;
        sel = w8;
        core_dly = dly;
        w = w8 ? 8 : 1;
        key   = {$urandom, $urandom, $urandom, $urandom};
        nonce = {$urandom, $urandom, $urandom, $urandom};
        ad    = {8'($urandom), 32'($urandom)};
        text  = {8'($urandom), 32'($urandom)};
        etag  = flip ? (TAG ^ (128'd1 << $urandom_range(0, 127))) : TAG;
        ib    = {key, nonce, ad, text, etag};
        eb    = dec ? {text ^ MASK, 128'd0} : {text ^ MASK, TAG};
        n_in  = (dec ? 464 : 336) / w;
        n_out = (dec ? 40 : 168) / w;

        mode = dec;
        start = 1'b1;
        step();
        start = 1'b0;
        mode = ~dec;
        checks++;
        if (ir !== 1'b1) begin
            errors++;
            $display("FAIL start_to_ready w=%0d: in_ready=%b want 1", w, ir);
        end

        i = 0;
        cyc = 0;
        while (i < n_in && cyc < 20000) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            d = '0;
            for (int b = 0; b < w; b++) d = {d[6:0], ib[463 - i * w - b]};
            in_data = d;
            acc = in_valid && ir;
            step();
            cyc++;
            if (acc) i++;
        end
        in_valid = 1'b0;
        in_data = '0;
        checks++;
        if (i != n_in) begin
            errors++;
            $display("FAIL load_timeout w=%0d: accepted=%0d want %0d", w, i, n_in);
        end

        cyc = 0; nb = 0; starts = 0; done_cyc = -1; first_ov = -1; auth_cyc = -1;
        stall_left = 0; did_stall = 0; aok_seen = 0; fin = 0; held = '0;
        while (!fin && cyc < 3000) begin
            if (cs) begin
                starts++;
                checks++;
                if ({ck, cn, ca, ct, cm} !== {key, nonce, ad, text, dec}) begin
                    errors++;
                    $display("FAIL core_inputs w=%0d: key=%h nonce=%h ad=%h text=%h mode=%b",
                             w, ck, cn, ca, ct, cm);
                end
            end
            if (c_done && done_cyc < 0) done_cyc = cyc;
            if (av) begin
                auth_cyc = cyc;
                aok_seen = ao;
                checks++;
                if (busy !== !flip) begin
                    errors++;
                    $display("FAIL auth_next_state: busy=%b want %b", busy, !flip);
                end
            end
            start = run_start && busy && !ov && cyc == 1;
            if (ov) begin
                if (first_ov < 0) first_ov = cyc;
                if (stall && nb == 2 && !did_stall) begin
                    did_stall = 1;
                    held = od;
                    stall_left = 2;
                    out_ready = 1'b0;
                end else if (stall_left > 0) begin
                    stall_left--;
                    out_ready = 1'b0;
                    checks++;
                    if (od !== held) begin
                        errors++;
                        $display("FAIL stall_hold: out_data=%h want %h", od, held);
                    end
                end else begin
                    out_ready = 1'b1;
                end
                if (out_ready) begin
                    e = '0;
                    for (int b = 0; b < w; b++) e = {e[6:0], eb[167 - nb * w - b]};
                    checks++;
                    if (od !== e || ol !== (nb == n_out - 1)) begin
                        errors++;
                        $display("FAIL out_beat %0d w=%0d: data=%h last=%b want %h %b",
                                 nb, w, od, ol, e, nb == n_out - 1);
                    end
                    nb++;
                    if (nb == n_out) begin
                        start = last_start;
                        fin = 1;
                    end
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            if (flip && auth_cyc >= 0 && cyc >= auth_cyc + 2) fin = 1;
            if (nb > n_out) fin = 1;
            step();
            cyc++;
            start = 1'b0;
        end
        out_ready = 1'b0;

        checks++;
        if (busy !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL op_end w=%0d: busy=%b out_valid=%b want 0 0", w, busy, ov);
        end
        checks++;
        if (starts != 1) begin
            errors++;
            $display("FAIL core_start_count: %0d want 1", starts);
        end
        checks++;
        if (nb != (flip ? 0 : n_out)) begin
            errors++;
            $display("FAIL out_beat_count: %0d want %0d", nb, flip ? 0 : n_out);
        end
        if (!flip) begin
            checks++;
            if (first_ov != done_cyc + 1 || done_cyc < 0) begin
                errors++;
                $display("FAIL out_latency: first out_valid at %0d, core_done at %0d",
                         first_ov, done_cyc);
            end
        end
        checks++;
        if (dec) begin
            if (auth_cyc != done_cyc + 1 || done_cyc < 0 || aok_seen !== !flip) begin
                errors++;
                $display("FAIL auth: at %0d ok=%b, core_done at %0d, want ok=%b",
                         auth_cyc, aok_seen, done_cyc, !flip);
            end
        end else if (auth_cyc != -1) begin
            errors++;
            $display("FAIL auth_on_encrypt: auth_valid at %0d want none", auth_cyc);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset();
        sel = 1'b1;
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({busy, ir, ov, ol, cs, av, ao, cm} !== 8'b0 || od !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: flags=%b data=%h want 0",
                     {busy, ir, ov, ol, cs, av, ao, cm}, od);
        end
        checks++;
        if ({ck, cn, ca, ct} !== '0) begin
            errors++;
            $display("FAIL reset_core_data: key=%h text=%h want 0", ck, ct);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_encrypt_w1();
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    endtask

    task automatic test_encrypt_w8();
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    endtask

    task automatic test_decrypt_ok();
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    endtask

    task automatic test_decrypt_bad_tag();
        run_op(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        run_op(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    endtask

    task automatic test_core_done_same_cycle();
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_stall();
        run_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5);
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    endtask

    task automatic test_back_to_back();
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    endtask

    task automatic test_reset_mid_op();
        int n;
        bit bad;
        sel = 1'b1;
        mode = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (n < 20) begin
            in_valid = 1'b1;
            in_data = 8'($urandom);
            step();
            n++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({busy, ir, ov, ol, cs, av, ao, cm} !== 8'b0 || {ck, cn} !== '0) begin
            errors++;
            $display("FAIL midop_reset: flags=%b key=%h want 0",
                     {busy, ir, ov, ol, cs, av, ao, cm}, ck);
        end
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (cs !== 1'b0 || busy !== 1'b0) bad = 1;
            step();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL midop_reset_quiet: core_start/busy seen after reset, want none");
        end
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        sel = 1'b1;
        test_reset();
        test_encrypt_w1();
        test_encrypt_w8();
        test_decrypt_ok();
        test_decrypt_bad_tag();
        test_core_done_same_cycle();
        test_stall();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
